// File: rtl/ps2_ascii_decoder_if.sv
// PS/2 keyboard pins plus the decoded key outputs, in one bundle.
// master: keyboard side (drives ps2_clk/ps2_data, observes results).
// slave : decoder side (samples PS/2 pins, drives decoded outputs).
interface ps2_ascii_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] kbdata;
    logic [7:0] scan_code;
    logic       key_valid;
    logic [7:0] key_count;
    logic       frame_err;
    logic       overflow;

    modport master (
        output ps2_clk, ps2_data,
        input  kbdata, scan_code, key_valid, key_count, frame_err, overflow
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output kbdata, scan_code, key_valid, key_count, frame_err, overflow
    );
endinterface

// File: rtl/ps2_ascii_decoder.sv
// PS/2 receiver + raw-byte FIFO + make/break decoder producing held-key ASCII.
// Latency: outputs update 3 clk after the synchronised 11th ps2_clk falling edge.
// Backpressure: none; FIFO drains one byte/clk, a push into a full non-draining FIFO sets sticky overflow.
//
// Ports: clk, clrn (async active-low); bus (slave modport): ps2_clk/ps2_data in,
//        kbdata, scan_code, key_valid, key_count, frame_err, overflow out.
// Optional: define SHIFT_CASE_EN to track shift and emit lower-case letters when unshifted.
module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               clrn,
    ps2_ascii_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} dec_state_t;

    // ---------------- synchronisers ----------------
    logic [2:0] clk_sync;
    logic [1:0] dat_sync;
    logic       fall;
    logic       din;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], bus.ps2_clk};
            dat_sync <= {dat_sync[0], bus.ps2_data};
        end
    end

    assign fall = (clk_sync[2:1] == 2'b10);
    // Data taken at the same depth as clk_sync[1] so it lines up with the edge.
    assign din  = dat_sync[1];

    // ---------------- receiver ----------------
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;   // [0]=start, [8:1]=data, [9]=parity once 10 bits are in
    logic [TW-1:0] wdog;
    logic          push_vld;
    logic [7:0]    push_dat;
    logic          frame_err_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            wdog        <= '0;
            push_vld    <= 1'b0;
            push_dat    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_vld    <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                wdog <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    // din is the stop bit here; it never enters the shift register.
                    if (!shreg[0] && din && (^shreg[9:1])) begin
                        push_vld <= 1'b1;
                        push_dat <= shreg[8:1];
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {din, shreg[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (wdog == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt     <= '0;
                    wdog        <= '0;
                    frame_err_q <= 1'b1;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

    // ---------------- raw-byte FIFO ----------------
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic [7:0]  rd_dat;
    logic        overflow_q;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_pop   = !fifo_empty;
    // A pop in the same cycle frees the slot, so push is accepted even when full.
    assign fifo_push  = push_vld && (!fifo_full || fifo_pop);
    assign rd_dat     = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !fifo_push) overflow_q <= 1'b1;
        end
    end

    // ---------------- decoder ----------------
    function automatic logic [7:0] map_upper(input logic [7:0] sc);
        case (sc)
            8'h1C: map_upper = 8'd65;  8'h32: map_upper = 8'd66;  8'h21: map_upper = 8'd67;
            8'h23: map_upper = 8'd68;  8'h24: map_upper = 8'd69;  8'h2B: map_upper = 8'd70;
            8'h34: map_upper = 8'd71;  8'h33: map_upper = 8'd72;  8'h43: map_upper = 8'd73;
            8'h3B: map_upper = 8'd74;  8'h42: map_upper = 8'd75;  8'h4B: map_upper = 8'd76;
            8'h3A: map_upper = 8'd77;  8'h31: map_upper = 8'd78;  8'h44: map_upper = 8'd79;
            8'h4D: map_upper = 8'd80;  8'h15: map_upper = 8'd81;  8'h2D: map_upper = 8'd82;
            8'h1B: map_upper = 8'd83;  8'h2C: map_upper = 8'd84;  8'h3C: map_upper = 8'd85;
            8'h2A: map_upper = 8'd86;  8'h1D: map_upper = 8'd87;  8'h22: map_upper = 8'd88;
            8'h35: map_upper = 8'd89;  8'h1A: map_upper = 8'd90;
            8'h45: map_upper = 8'd48;  8'h16: map_upper = 8'd49;  8'h1E: map_upper = 8'd50;
            8'h26: map_upper = 8'd51;  8'h25: map_upper = 8'd52;  8'h2E: map_upper = 8'd53;
            8'h36: map_upper = 8'd54;  8'h3D: map_upper = 8'd55;  8'h3E: map_upper = 8'd56;
            8'h46: map_upper = 8'd57;  8'h29: map_upper = 8'd32;
            default: map_upper = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] a);
        fold = (a >= 8'd97 && a <= 8'd122) ? a - 8'd32 : a;
    endfunction

    dec_state_t state, state_nxt;
    logic [7:0] kbdata_q, kbdata_nxt, scan_q, scan_nxt, count_q, count_nxt;
    logic       kv_q, kv_nxt;
    logic [7:0] upper, ascii;
    logic       same_key;

    assign upper = map_upper(rd_dat);
`ifdef SHIFT_CASE_EN
    logic shift_q, shift_nxt;
    assign ascii = (!shift_q && upper >= 8'd65 && upper <= 8'd90) ? upper + 8'd32 : upper;
`else
    assign ascii = upper;
`endif
    // Case-insensitive match so a shift change alone never re-triggers or strands a key.
    assign same_key = (fold(ascii) == fold(kbdata_q));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            kbdata_q <= '0;
            scan_q   <= '0;
            count_q  <= '0;
            kv_q     <= 1'b0;
`ifdef SHIFT_CASE_EN
            shift_q  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            kbdata_q <= kbdata_nxt;
            scan_q   <= scan_nxt;
            count_q  <= count_nxt;
            kv_q     <= kv_nxt;
`ifdef SHIFT_CASE_EN
            shift_q  <= shift_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        kbdata_nxt = kbdata_q;
        scan_nxt   = scan_q;
        count_nxt  = count_q;
        kv_nxt     = 1'b0;
`ifdef SHIFT_CASE_EN
        shift_nxt  = shift_q;
`endif
        if (fifo_pop) begin
            case (state)
                IDLE: begin
                    if (rd_dat == 8'hF0) begin
                        state_nxt = BREAK;
                    end else if (rd_dat == 8'hE0) begin
                        state_nxt = EXT;
                    end else begin
                        scan_nxt = rd_dat;
`ifdef SHIFT_CASE_EN
                        if (rd_dat == 8'h12 || rd_dat == 8'h59) shift_nxt = 1'b1;
`endif
                        if (ascii != 8'd0 && !same_key) begin
                            kbdata_nxt = ascii;
                            kv_nxt     = 1'b1;
                            count_nxt  = count_q + 8'd1;
                        end
                    end
                end
                BREAK: begin
                    scan_nxt  = rd_dat;
                    state_nxt = IDLE;
`ifdef SHIFT_CASE_EN
                    if (rd_dat == 8'h12 || rd_dat == 8'h59) shift_nxt = 1'b0;
`endif
                    if (ascii != 8'd0 && same_key) kbdata_nxt = 8'd0;
                end
                EXT:       state_nxt = (rd_dat == 8'hF0) ? EXT_BREAK : IDLE;
                EXT_BREAK: state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    assign bus.kbdata    = kbdata_q;
    assign bus.scan_code = scan_q;
    assign bus.key_valid = kv_q;
    assign bus.key_count = count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench: table of PS/2 frames with expected decoder outputs,
// plus hand sequences for exact latency and the mid-frame timeout.
module tb_ps2_ascii_decoder;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    ps2_ascii_decoder_if bus();

    ps2_ascii_decoder dut (.clk(clk), .clrn(clrn), .bus(bus));

`ifdef SHIFT_CASE_EN
    localparam logic [7:0] LC = 8'd32;
`else
    localparam logic [7:0] LC = 8'd0;
`endif
    localparam logic [7:0] ASC_A = 8'd65 + LC;
    localparam logic [7:0] ASC_B = 8'd66 + LC;

    typedef struct {
        logic [7:0] code;
        logic       bad;
        logic [7:0] kb;
        logic [7:0] sc;
        logic [7:0] cnt;
        int         fe;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    int checks = 0;
    int errors = 0;
    int kv_pulses = 0;
    int fe_pulses = 0;

    always @(negedge clk) begin
        if (clrn && bus.key_valid) kv_pulses++;
        if (clrn && bus.frame_err) fe_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
        logic par;
        par = ~(^b) ^ bad;
        return {1'b1, par, b, 1'b0};
    endfunction

    // One full ps2_clk period (100 clk): data set while high, low for 50 clk.
    task automatic drive_bit(input logic v);
        @(negedge clk);
        bus.ps2_data = v;
        repeat (25) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (50) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad, input int nedges);
        logic [10:0] bits;
        bits = frame_bits(b, bad);
        for (int i = 0; i < nedges; i++) drive_bit(bits[i]);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        send_frame(v.code, v.bad, 11);
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_%02h kbdata", idx, v.code), {24'd0, bus.kbdata}, {24'd0, v.kb});
        check($sformatf("v%0d_%02h scan_code", idx, v.code), {24'd0, bus.scan_code}, {24'd0, v.sc});
        check($sformatf("v%0d_%02h key_count", idx, v.code), {24'd0, bus.key_count}, {24'd0, v.cnt});
        check($sformatf("v%0d_%02h key_valid_pulses", idx, v.code), kv_pulses, {24'd0, v.cnt});
        check($sformatf("v%0d_%02h frame_err_pulses", idx, v.code), fe_pulses, v.fe);
    endtask

    initial begin
        logic [10:0] bits;
        int cyc;
        bit seen;

        // tbl_a follows the latency test (1C held: kbdata=A, count 1)
        tbl_a.push_back('{8'hF0, 1'b0, ASC_A, 8'h1C, 8'd1, 0});
        tbl_a.push_back('{8'h1C, 1'b0, 8'd0,  8'h1C, 8'd1, 0});
        tbl_a.push_back('{8'h1C, 1'b0, ASC_A, 8'h1C, 8'd2, 0});
        tbl_a.push_back('{8'h1C, 1'b0, ASC_A, 8'h1C, 8'd2, 0});
        tbl_a.push_back('{8'h1C, 1'b0, ASC_A, 8'h1C, 8'd2, 0});
        tbl_a.push_back('{8'h32, 1'b0, ASC_B, 8'h32, 8'd3, 0});
        tbl_a.push_back('{8'hF0, 1'b0, ASC_B, 8'h32, 8'd3, 0});
        tbl_a.push_back('{8'h1C, 1'b0, ASC_B, 8'h1C, 8'd3, 0});
        tbl_a.push_back('{8'h16, 1'b1, ASC_B, 8'h1C, 8'd3, 1});
        // tbl_b follows the timeout sequence
        tbl_b.push_back('{8'h16, 1'b0, 8'd49, 8'h16, 8'd4, 2});
        tbl_b.push_back('{8'hE0, 1'b0, 8'd49, 8'h16, 8'd4, 2});
        tbl_b.push_back('{8'h75, 1'b0, 8'd49, 8'h16, 8'd4, 2});
        tbl_b.push_back('{8'hE0, 1'b0, 8'd49, 8'h16, 8'd4, 2});
        tbl_b.push_back('{8'hF0, 1'b0, 8'd49, 8'h16, 8'd4, 2});
        tbl_b.push_back('{8'h75, 1'b0, 8'd49, 8'h16, 8'd4, 2});
        tbl_b.push_back('{8'h29, 1'b0, 8'd32, 8'h29, 8'd5, 2});
`ifdef SHIFT_CASE_EN
        tbl_b.push_back('{8'h1C, 1'b0, 8'd97, 8'h1C, 8'd6, 2});
        tbl_b.push_back('{8'h12, 1'b0, 8'd97, 8'h12, 8'd6, 2});
        tbl_b.push_back('{8'h1C, 1'b0, 8'd97, 8'h1C, 8'd6, 2});
        tbl_b.push_back('{8'hF0, 1'b0, 8'd97, 8'h1C, 8'd6, 2});
        tbl_b.push_back('{8'h1C, 1'b0, 8'd0,  8'h1C, 8'd6, 2});
        tbl_b.push_back('{8'h32, 1'b0, 8'd66, 8'h32, 8'd7, 2});
`endif

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        clrn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_kbdata", {24'd0, bus.kbdata}, 32'd0);
        check("rst_key_valid", {31'd0, bus.key_valid}, 32'd0);
        clrn = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_kbdata", {24'd0, bus.kbdata}, 32'd0);
        check("idle_scan_code", {24'd0, bus.scan_code}, 32'd0);
        check("idle_key_count", {24'd0, bus.key_count}, 32'd0);
        check("idle_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("idle_overflow", {31'd0, bus.overflow}, 32'd0);

        // Exact latency: 0x1C, outputs appear 5 clk after ps2_clk falls
        // (2 sync stages + 3 pipeline stages).
        bits = frame_bits(8'h1C, 1'b0);
        for (int i = 0; i < 10; i++) drive_bit(bits[i]);
        @(negedge clk);
        bus.ps2_data = bits[10];
        repeat (25) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("lat_kbdata_early", {24'd0, bus.kbdata}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_kbdata", {24'd0, bus.kbdata}, {24'd0, ASC_A});
        check("lat_key_valid", {31'd0, bus.key_valid}, 32'd1);
        @(posedge clk);
        #1;
        check("lat_key_valid_fall", {31'd0, bus.key_valid}, 32'd0);
        repeat (44) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (24) @(negedge clk);
        check("lat_key_count", {24'd0, bus.key_count}, 32'd1);
        check("lat_pulses", kv_pulses, 32'd1);

        for (int i = 0; i < tbl_a.size(); i++) run_vec(tbl_a[i], i);

        // Timeout: 5 edges then ps2_clk stays high.
        bits = frame_bits(8'h16, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(bits[i]);
        @(negedge clk);
        bus.ps2_data = bits[4];
        repeat (25) @(negedge clk);
        bus.ps2_clk = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 60000 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 50) bus.ps2_clk = 1'b1;
            if (bus.frame_err) seen = 1'b1;
        end
        check("timeout_seen", {31'd0, seen}, 32'd1);
        check("timeout_window", {31'd0, (cyc >= 49990 && cyc <= 50010)}, 32'd1);
        repeat (5) @(negedge clk);
        check("timeout_pulses", fe_pulses, 32'd2);
        check("timeout_kbdata", {24'd0, bus.kbdata}, {24'd0, ASC_B});

        for (int i = 0; i < tbl_b.size(); i++) run_vec(tbl_b[i], 100 + i);

        check("end_overflow", {31'd0, bus.overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
